// File: rtl/core_fetch_queue_if.sv
// Instruction-memory request/grant/response bus between the fetch stage and instruction memory.
interface core_fetch_queue_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              instr_en;
   logic [ADDR_W-1:0] instr_addr;
   logic              instr_gnt;
   logic              instr_rvalid;
   logic [DATA_W-1:0] instr_data;

   modport master (
      output instr_en, instr_addr,
      input  instr_gnt, instr_rvalid, instr_data
   );

   modport slave (
      input  instr_en, instr_addr,
      output instr_gnt, instr_rvalid, instr_data
   );
endinterface

// File: rtl/core_fetch_queue.sv
// Instruction fetch stage: keeps up to DEPTH requests in flight and buffers {PC, instr}
// in a prefetch queue; handles branch/jump redirect, flush and decode stall.
module core_fetch_queue #(
   parameter int unsigned      ADDR_W   = 32,
   parameter int unsigned      DATA_W   = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic                i_StallEn,
   input  logic                i_FlushEn,
   input  logic                i_BranchEn,
   input  logic [ADDR_W-1:0]   i_BranchAddr,
   input  logic                i_JumpEn,
   input  logic [ADDR_W-1:0]   i_JumpAddr,
   core_fetch_queue_if.master  imem,
   output logic                o_Valid,
   output logic [DATA_W-1:0]   o_InstrData,
   output logic [ADDR_W-1:0]   o_PC,
   output logic                o_Event
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   logic [ADDR_W-1:0] fpc;
   entry_t            q_mem   [DEPTH];
   logic [ADDR_W-1:0] tag_mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr, tag_rd, tag_wr;
   logic [CNT_W-1:0]  cnt, out_cnt, dis;
   logic              event_q;

   logic              redirect, discard, credit_ok, issue, grant, resp, drop, push, pop, q_we, event_nxt;
   logic [ADDR_W-1:0] target, flush_pc;
   logic [PTR_W-1:0]  live_idx;

   // Request credit covers both buffered entries and everything still in flight
   always_comb begin
      redirect  = i_JumpEn | i_BranchEn;
      discard   = redirect | i_FlushEn;
      target    = i_JumpEn ? i_JumpAddr : i_BranchAddr;
      credit_ok = (SUM_W'(cnt) + SUM_W'(out_cnt)) < SUM_W'(DEPTH);
      issue     = ~i_Rst & ~discard & credit_ok;
      grant     = issue & imem.instr_gnt;
      resp      = imem.instr_rvalid;
      drop      = resp & (dis != '0);
      push      = resp & ~drop;
      pop       = o_Valid & ~i_StallEn;
      q_we      = push & ~discard & ~i_Rst;
      event_nxt = redirect & ((i_JumpEn & i_BranchEn) | (target[1:0] != 2'b00));
      // Oldest request whose response will still be kept (skips already-discarded tags)
      live_idx  = tag_rd + PTR_W'(dis);
      if (cnt != '0)
         flush_pc = q_mem[rd_ptr].pc;
      else if (out_cnt > dis)
         flush_pc = tag_mem[live_idx];
      else
         flush_pc = fpc;
   end

   assign imem.instr_en   = issue;
   assign imem.instr_addr = fpc;

   assign o_Valid     = (cnt != '0);
   assign o_PC        = o_Valid ? q_mem[rd_ptr].pc    : '0;
   assign o_InstrData = o_Valid ? q_mem[rd_ptr].instr : '0;
   assign o_Event     = event_q;

   // Storage arrays: no reset needed, contents are qualified by the counters
   always_ff @(posedge i_Clk) begin
      if (grant)
         tag_mem[tag_wr] <= fpc;
      if (q_we)
         q_mem[wr_ptr] <= '{pc: tag_mem[tag_rd], instr: imem.instr_data};
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         fpc     <= RESET_PC;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         tag_rd  <= '0;
         tag_wr  <= '0;
         cnt     <= '0;
         out_cnt <= '0;
         dis     <= '0;
         event_q <= 1'b0;
      end else begin
         event_q <= event_nxt;
         out_cnt <= out_cnt + CNT_W'(grant) - CNT_W'(resp);
         if (grant)
            tag_wr <= tag_wr + PTR_W'(1);
         if (resp)
            tag_rd <= tag_rd + PTR_W'(1);
         if (discard) begin
            cnt    <= '0;
            rd_ptr <= wr_ptr;
            dis    <= out_cnt - CNT_W'(resp);
            fpc    <= redirect ? (target & ~ADDR_W'(3)) : flush_pc;
         end else begin
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
            dis <= dis - CNT_W'(drop);
            if (push)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
            if (grant)
               fpc <= fpc + ADDR_W'(4);
         end
      end
   end
endmodule

// File: tb/tb_core_fetch_queue.sv
// Directed self-checking bench for core_fetch_queue with an in-order memory model.
module tb_core_fetch_queue;
   localparam logic [31:0] K = 32'hDEAD_0000;

   logic        i_Clk = 1'b0;
   logic        i_Rst, i_StallEn, i_FlushEn, i_BranchEn, i_JumpEn;
   logic [31:0] i_BranchAddr, i_JumpAddr;
   logic        o_Valid, o_Event;
   logic [31:0] o_InstrData, o_PC;
   logic        b_Valid, b_Event;
   logic [31:0] b_InstrData, b_PC;

   logic        mem_gnt;
   logic        mem_lat2;
   logic [3:0]  pv;
   logic [31:0] pa [4];
   logic        rv_b;
   logic [31:0] ra_b;

   int checks = 0;
   int failures = 0;

   core_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) mif ();
   core_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) mif_b ();

   core_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_StallEn(i_StallEn), .i_FlushEn(i_FlushEn),
      .i_BranchEn(i_BranchEn), .i_BranchAddr(i_BranchAddr), .i_JumpEn(i_JumpEn),
      .i_JumpAddr(i_JumpAddr), .imem(mif), .o_Valid(o_Valid), .o_InstrData(o_InstrData),
      .o_PC(o_PC), .o_Event(o_Event)
   );

   core_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_StallEn(1'b0), .i_FlushEn(1'b0),
      .i_BranchEn(1'b0), .i_BranchAddr(32'h0), .i_JumpEn(1'b0),
      .i_JumpAddr(32'h0), .imem(mif_b), .o_Valid(b_Valid), .o_InstrData(b_InstrData),
      .o_PC(b_PC), .o_Event(b_Event)
   );

   always #5 i_Clk = ~i_Clk;

   // In-order memory: response 1 or 2 cycles after grant, data = addr ^ K
   always @(posedge i_Clk) begin
      if (i_Rst) begin
         pv <= '0;
      end else begin
         pv <= {1'b0, pv[3:1]};
         for (int i = 0; i < 3; i++) pa[i] <= pa[i+1];
         if (mif.instr_en && mif.instr_gnt) begin
            pv[mem_lat2 ? 1 : 0] <= 1'b1;
            pa[mem_lat2 ? 1 : 0] <= mif.instr_addr;
         end
      end
   end
   assign mif.instr_gnt    = mem_gnt;
   assign mif.instr_rvalid = pv[0];
   assign mif.instr_data   = pa[0] ^ K;

   always @(posedge i_Clk) begin
      if (i_Rst) rv_b <= 1'b0;
      else begin
         rv_b <= mif_b.instr_en & mif_b.instr_gnt;
         ra_b <= mif_b.instr_addr;
      end
   end
   assign mif_b.instr_gnt    = 1'b1;
   assign mif_b.instr_rvalid = rv_b;
   assign mif_b.instr_data   = ra_b ^ K;

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic do_reset();
      i_Rst = 1'b1; i_StallEn = 1'b0; i_FlushEn = 1'b0; i_BranchEn = 1'b0; i_JumpEn = 1'b0;
      mem_gnt = 1'b1;
      tick();
      tick();
      i_Rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      i_Rst = 1'b1;
      tick(); tick();
      checks += 7;
      if (mif.instr_en !== 1'b0) begin failures++; $display("FAIL reset_en: got %b expected 0", mif.instr_en); end
      if (mif.instr_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 00000000", mif.instr_addr); end
      if (o_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_Valid); end
      if (o_InstrData !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", o_InstrData); end
      if (o_PC !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 0", o_PC); end
      if (o_Event !== 1'b0) begin failures++; $display("FAIL reset_event: got %b expected 0", o_Event); end
      if (mif_b.instr_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL reset_addr_b: got %h expected fffffff8", mif_b.instr_addr); end
      i_Rst = 1'b0;
      #1;
      checks++;
      if (mif.instr_en !== 1'b1) begin failures++; $display("FAIL reset_first_en: got %b expected 1", mif.instr_en); end
      tick(); tick(); tick();
      i_Rst = 1'b1;
      tick();
      checks += 3;
      if (o_Valid !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b expected 0", o_Valid); end
      if (mif.instr_en !== 1'b0) begin failures++; $display("FAIL midreset_en: got %b expected 0", mif.instr_en); end
      if (mif.instr_addr !== 32'h0) begin failures++; $display("FAIL midreset_addr: got %h expected 0", mif.instr_addr); end
   endtask

   task automatic test_streaming();
      logic [31:0] exp_pc;
      do_reset();
      checks++;
      if (mif.instr_en !== 1'b1 || mif.instr_addr !== 32'h0) begin failures++; $display("FAIL stream_first_req: en=%b addr=%h expected en=1 addr=0", mif.instr_en, mif.instr_addr); end
      tick();
      checks++;
      if (o_Valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid: got %b expected 0", o_Valid); end
      tick();
      for (int k = 0; k < 6; k++) begin
         exp_pc = 32'(4 * k);
         checks++;
         if (o_Valid !== 1'b1 || o_PC !== exp_pc || o_InstrData !== (exp_pc ^ K)) begin
            failures++; $display("FAIL stream[%0d]: valid=%b pc=%h data=%h expected pc=%h data=%h", k, o_Valid, o_PC, o_InstrData, exp_pc, exp_pc ^ K);
         end
         if (k < 3) begin
            exp_pc = 32'hFFFF_FFF8 + 32'(4 * k);
            checks++;
            if (b_Valid !== 1'b1 || b_PC !== exp_pc || b_InstrData !== (exp_pc ^ K)) begin
               failures++; $display("FAIL wrap[%0d]: valid=%b pc=%h data=%h expected pc=%h", k, b_Valid, b_PC, b_InstrData, exp_pc);
            end
         end
         tick();
      end
   endtask

   task automatic test_grant_hold();
      int got;
      logic [31:0] exp_pc;
      do_reset();
      mem_gnt = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (mif.instr_en !== 1'b1 || mif.instr_addr !== 32'h0 || o_Valid !== 1'b0) begin
         failures++; $display("FAIL hold_addr: en=%b addr=%h valid=%b expected en=1 addr=0 valid=0", mif.instr_en, mif.instr_addr, o_Valid);
      end
      mem_gnt = 1'b1;
      got = 0;
      for (int c = 0; c < 30 && got < 3; c++) begin
         if (o_Valid && !i_StallEn) begin
            exp_pc = 32'(4 * got);
            checks++;
            if (o_PC !== exp_pc || o_InstrData !== (exp_pc ^ K)) begin failures++; $display("FAIL hold_seq[%0d]: pc=%h expected %h", got, o_PC, exp_pc); end
            got++;
         end
         tick();
      end
      checks++;
      if (got != 3) begin failures++; $display("FAIL hold_count: got %0d expected 3", got); end
   endtask

   task automatic test_stall_fill();
      int got;
      logic [31:0] exp_pc;
      do_reset();
      i_StallEn = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      checks++;
      if (mif.instr_en !== 1'b0 || mif.instr_addr !== 32'h10 || o_Valid !== 1'b1 || o_PC !== 32'h0) begin
         failures++; $display("FAIL stall_full: en=%b addr=%h valid=%b pc=%h expected en=0 addr=10 valid=1 pc=0", mif.instr_en, mif.instr_addr, o_Valid, o_PC);
      end
      i_StallEn = 1'b0;
      got = 0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         if (o_Valid && !i_StallEn) begin
            exp_pc = 32'(4 * got);
            checks++;
            if (o_PC !== exp_pc || o_InstrData !== (exp_pc ^ K)) begin failures++; $display("FAIL stall_seq[%0d]: pc=%h data=%h expected pc=%h", got, o_PC, o_InstrData, exp_pc); end
            got++;
         end
         tick();
      end
      checks++;
      if (got != 8) begin failures++; $display("FAIL stall_count: got %0d expected 8", got); end
   endtask

   task automatic test_branch_inflight();
      int got;
      logic [31:0] exp_pc;
      mem_lat2 = 1'b1;
      do_reset();
      tick(); tick(); tick();
      checks++;
      if (o_Valid !== 1'b1 || o_PC !== 32'h0) begin failures++; $display("FAIL branch_pre: valid=%b pc=%h expected valid=1 pc=0", o_Valid, o_PC); end
      i_BranchEn = 1'b1; i_BranchAddr = 32'h100;
      tick();
      i_BranchEn = 1'b0;
      #1;
      checks++;
      if (mif.instr_en !== 1'b1 || mif.instr_addr !== 32'h100 || o_Valid !== 1'b0 || o_Event !== 1'b0) begin
         failures++; $display("FAIL branch_req: en=%b addr=%h valid=%b event=%b expected en=1 addr=100 valid=0 event=0", mif.instr_en, mif.instr_addr, o_Valid, o_Event);
      end
      got = 0;
      for (int c = 0; c < 30 && got < 3; c++) begin
         if (o_Valid && !i_StallEn) begin
            exp_pc = 32'h100 + 32'(4 * got);
            checks++;
            if (o_PC !== exp_pc || o_InstrData !== (exp_pc ^ K)) begin failures++; $display("FAIL branch_seq[%0d]: pc=%h data=%h expected pc=%h", got, o_PC, o_InstrData, exp_pc); end
            got++;
         end
         tick();
      end
      checks++;
      if (got != 3) begin failures++; $display("FAIL branch_count: got %0d expected 3", got); end
      mem_lat2 = 1'b0;
   endtask

   task automatic test_jump_branch();
      int got;
      logic [31:0] exp_pc;
      do_reset();
      tick(); tick(); tick();
      i_JumpEn = 1'b1; i_JumpAddr = 32'h200;
      i_BranchEn = 1'b1; i_BranchAddr = 32'h300;
      tick();
      i_JumpEn = 1'b0; i_BranchEn = 1'b0;
      #1;
      checks++;
      if (o_Event !== 1'b1 || mif.instr_addr !== 32'h200 || mif.instr_en !== 1'b1) begin
         failures++; $display("FAIL jb_event: event=%b addr=%h en=%b expected event=1 addr=200 en=1", o_Event, mif.instr_addr, mif.instr_en);
      end
      tick();
      checks++;
      if (o_Event !== 1'b0 || o_Valid !== 1'b0) begin failures++; $display("FAIL jb_pulse: event=%b valid=%b expected 0 0", o_Event, o_Valid); end
      tick();
      got = 0;
      for (int c = 0; c < 3; c++) begin
         exp_pc = 32'h200 + 32'(4 * c);
         checks++;
         if (o_Valid !== 1'b1 || o_PC !== exp_pc) begin failures++; $display("FAIL jb_seq[%0d]: valid=%b pc=%h expected pc=%h", c, o_Valid, o_PC, exp_pc); end
         tick();
      end
      // misaligned jump target alone
      i_JumpEn = 1'b1; i_JumpAddr = 32'h202;
      tick();
      i_JumpEn = 1'b0;
      #1;
      checks++;
      if (o_Event !== 1'b1 || mif.instr_addr !== 32'h200) begin failures++; $display("FAIL misalign_event: event=%b addr=%h expected event=1 addr=200", o_Event, mif.instr_addr); end
      for (int c = 0; c < 30 && got < 2; c++) begin
         if (o_Valid && !i_StallEn) begin
            exp_pc = 32'h200 + 32'(4 * got);
            checks++;
            if (o_PC !== exp_pc || o_InstrData !== (exp_pc ^ K)) begin failures++; $display("FAIL misalign_seq[%0d]: pc=%h expected %h", got, o_PC, exp_pc); end
            got++;
         end
         tick();
      end
      checks++;
      if (got != 2) begin failures++; $display("FAIL misalign_count: got %0d expected 2", got); end
   endtask

   task automatic test_flush();
      int got;
      logic [31:0] exp_pc;
      do_reset();
      for (int c = 0; c < 20 && !(o_Valid && o_PC == 32'h10); c++) tick();
      i_StallEn = 1'b1;
      tick(); tick();
      checks++;
      if (o_Valid !== 1'b1 || o_PC !== 32'h10 || mif.instr_en !== 1'b0) begin
         failures++; $display("FAIL flush_pre: valid=%b pc=%h en=%b expected valid=1 pc=10 en=0", o_Valid, o_PC, mif.instr_en);
      end
      i_FlushEn = 1'b1;
      tick();
      i_FlushEn = 1'b0; i_StallEn = 1'b0;
      #1;
      checks++;
      if (o_Valid !== 1'b0 || mif.instr_en !== 1'b1 || mif.instr_addr !== 32'h10) begin
         failures++; $display("FAIL flush_req: valid=%b en=%b addr=%h expected valid=0 en=1 addr=10", o_Valid, mif.instr_en, mif.instr_addr);
      end
      got = 0;
      for (int c = 0; c < 30 && got < 3; c++) begin
         if (o_Valid && !i_StallEn) begin
            exp_pc = 32'h10 + 32'(4 * got);
            checks++;
            if (o_PC !== exp_pc || o_InstrData !== (exp_pc ^ K)) begin failures++; $display("FAIL flush_seq[%0d]: pc=%h expected %h", got, o_PC, exp_pc); end
            got++;
         end
         tick();
      end
      checks++;
      if (got != 3) begin failures++; $display("FAIL flush_count: got %0d expected 3", got); end
   endtask

   task automatic test_flush_inflight();
      int got;
      logic [31:0] exp_pc;
      do_reset();
      tick();
      checks++;
      if (mif.instr_addr !== 32'h4 || o_Valid !== 1'b0) begin failures++; $display("FAIL flushif_pre: addr=%h valid=%b expected addr=4 valid=0", mif.instr_addr, o_Valid); end
      i_FlushEn = 1'b1;
      tick();
      i_FlushEn = 1'b0;
      #1;
      checks++;
      if (mif.instr_addr !== 32'h0 || mif.instr_en !== 1'b1) begin failures++; $display("FAIL flushif_req: addr=%h en=%b expected addr=0 en=1", mif.instr_addr, mif.instr_en); end
      got = 0;
      for (int c = 0; c < 30 && got < 3; c++) begin
         if (o_Valid && !i_StallEn) begin
            exp_pc = 32'(4 * got);
            checks++;
            if (o_PC !== exp_pc) begin failures++; $display("FAIL flushif_seq[%0d]: pc=%h expected %h", got, o_PC, exp_pc); end
            got++;
         end
         tick();
      end
      checks++;
      if (got != 3) begin failures++; $display("FAIL flushif_count: got %0d expected 3", got); end
   endtask

   initial begin
      i_Rst = 1'b1; i_StallEn = 1'b0; i_FlushEn = 1'b0; i_BranchEn = 1'b0; i_JumpEn = 1'b0;
      i_BranchAddr = 32'h0; i_JumpAddr = 32'h0;
      mem_gnt = 1'b1; mem_lat2 = 1'b0;
      test_reset();
      test_streaming();
      test_grant_hold();
      test_stall_fill();
      test_branch_inflight();
      test_jump_branch();
      test_flush();
      test_flush_inflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/core_fetch_queue.md
# core_fetch_queue

Parametrised instruction-fetch stage with a decoupling prefetch queue, sitting between the instruction memory port and the decode stage. It keeps several fetch requests in flight on a request/grant/response memory interface and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It redirects on branch or jump, flushes on request, and holds its output while decode stalls. Illegal redirect conditions raise a one-cycle event.

## Interface
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, ≥2; also the maximum number of requests in flight.
- RESET_PC, 0, first fetch address after reset; low two bits are 0.

Reset: one clock; reset is synchronous and active-high.

- i_Clk  in  1  clock; all state changes on the rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_StallEn  in  1  decode cannot accept; hold the head entry.
- i_FlushEn  in  1  discard the queue and all in-flight data, then refetch from the head PC.
- i_BranchEn  in  1  redirect to i_BranchAddr.
- i_BranchAddr  in  ADDR_W  branch target.
- i_JumpEn  in  1  redirect to i_JumpAddr.
- i_JumpAddr  in  ADDR_W  jump target.
- o_InstrEn  out  1  memory request valid.
- o_InstrAddr  out  ADDR_W  request address; held stable until granted.
- i_InstrGnt  in  1  memory accepts the request this cycle.
- i_InstrRvalid  in  1  response valid. Responses return in order, one per granted request, at least 1 cycle after the grant.
- i_InstrData  in  DATA_W  response data.
- o_Valid  out  1  head entry is valid for decode.
- o_InstrData  out  DATA_W  head instruction.
- o_PC  out  ADDR_W  PC of the head instruction.
- o_Event  out  1  one-cycle error pulse.

## Operation
- State:
  - fetch PC `fpc`
  - FIFO of {PC, instr} with rd/wr pointers and count `cnt`
  - outstanding counter `out` (0..DEPTH)
  - discard counter `dis` (0..DEPTH)
- Issue: o_InstrEn = ~redirect & ~i_FlushEn & (cnt + out < DEPTH).
  - Grant (o_InstrEn & i_InstrGnt): `out`++ and `fpc` += 4; wraps modulo 2^ADDR_W.
  - Each request's PC is pushed into a DEPTH-entry PC tag FIFO.
- Response, when i_InstrRvalid:
  - `dis` > 0: `dis`--, `out`--, data dropped, PC tag popped.
  - Otherwise: {tag PC, i_InstrData} pushed into the queue, `out`--.
  - Overflow is impossible by the credit rule.
- Pop: o_Valid & ~i_StallEn removes the head. Push and pop in the same cycle are allowed, including at full and at empty+1.
- Redirect is i_JumpEn | i_BranchEn. Priority: i_Rst > jump > branch > flush > normal.
  - Queue is cleared, `dis` ← `out` − (response arriving this cycle), `fpc` ← target with bits [1:0] forced to 0. No request is issued that cycle.
  - Jump and branch together: jump wins, o_Event=1.
  - Target[1:0] ≠ 0: o_Event=1.
- Flush alone: queue and in-flight data are discarded as for a redirect.
  - `fpc` ← head PC if cnt > 0.
  - Else `fpc` ← PC of the oldest in-flight request if out > 0.
  - Else `fpc` is unchanged.
- The PC tag FIFO is not cleared on redirect; discarded responses consume their tags.
- o_Event is otherwise 0.

## Timing
- Reset values: o_InstrEn=0, o_InstrAddr=RESET_PC, o_Valid=0, o_InstrData=0, o_PC=0, o_Event=0, cnt=out=dis=0.
- o_InstrEn may first rise the cycle after i_Rst deasserts.
- Latency:
  - Response to o_Valid is 1 cycle (registered queue).
  - Redirect to first new request is 1 cycle.
  - With zero-wait memory, redirect to first valid instruction is 3 cycles.
- o_InstrAddr = `fpc`, registered. An address does not change while o_InstrEn=1 and i_InstrGnt=0, except on redirect, flush or reset.
- Throughput: one instruction per cycle when grant is always high and memory latency + 1 ≤ DEPTH.
- Reset mid-operation clears all counters. Responses to pre-reset requests are the memory's responsibility and never appear after reset.

## Test plan
- **Streaming:** reset, grant=1, 1-cycle response latency, no stall → o_PC = 0, 4, 8, 12… on consecutive cycles starting 3 cycles after reset release.
- **Stall fill:** hold i_StallEn=1 → o_InstrEn drops once cnt+out = DEPTH, o_Valid stays 1 with o_PC=0. Release → no instruction lost or duplicated.
- **Branch with in-flight data:** i_BranchEn=1, i_BranchAddr=0x100 while out=2 → the next two responses are dropped, o_PC sequence resumes 0x100, 0x104.
- **Jump and branch together:** i_JumpAddr=0x200, i_BranchAddr=0x300 → o_Event pulses 1 cycle, fetch resumes at 0x200. Separately, i_JumpAddr=0x202 → event pulses, fetch resumes at 0x200.
- **Flush:** i_FlushEn with head o_PC=0x10 and cnt=3 → queue empties, refetch starts at 0x10, and 0x10 is delivered again.
- **Address wrap:** RESET_PC=0xFFFFFFF8 → o_PC = 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
